// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared defaults, MEM-stage FSM states and counter sizing for mem_wb_pipe_stage
package mem_wb_pkg;
  localparam int DEF_DATA_W = 24;
  localparam int DEF_REG_ADDR_W = 4;
  localparam int DEF_MEM_DEPTH = 256;
  typedef enum logic {IDLE, BUSY} mem_state_e;
  function automatic int cnt_width(input int wait_cycles);
    return wait_cycles > 0 ? $clog2(wait_cycles + 1) : 1;
  endfunction
endpackage

// File: rtl/mem_wb_pipe_stage_data_mem_sp.sv
// data_mem_sp: single-port data memory, asynchronous read, synchronous write, contents never reset
module data_mem_sp #(
  parameter int DATA_W = 24,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata
);
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  assign rdata = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/mem_wb_pipe_stage.sv
// mem_wb_pipe_stage: EX/MEM reg + data memory + MEM/WB reg with wait states, stall and flush; MEMSTAGE_FWD_EN adds forwarding taps
module mem_wb_pipe_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int MEM_WAIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writeback_enable,
  input  logic                  mem_read_enable,
  input  logic                  mem_write_enable,
  input  logic [REG_ADDR_W-1:0] instruction_dest,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     write_data,
  input  logic                  flush,
  output logic                  stall,
  output logic                  writeback_enable_out,
  output logic [REG_ADDR_W-1:0] instruction_dest_out,
  output logic [DATA_W-1:0]     writeback_data_out
`ifdef MEMSTAGE_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_dest,
  output logic [DATA_W-1:0]     fwd_data
`endif
);
  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = cnt_width(MEM_WAIT);
  localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(MEM_WAIT);
  typedef struct packed {
    logic                  wb_en;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
    logic [DATA_W-1:0]     wdata;
  } ex_mem_t;
  typedef struct packed {
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } mem_wb_t;
  localparam ex_mem_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_t MEM_WB_BUBBLE = '0;
  ex_mem_t ex_mem_in, ex_mem_d, ex_mem_q;
  mem_wb_t mem_wb_d, mem_wb_q;
  mem_state_e state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic flush_pending_d, flush_pending_q;
  logic mem_op, mem_we;
  logic [DATA_W-1:0] rd_data;
  assign mem_op = ex_mem_q.mem_rd | ex_mem_q.mem_wr;
  assign mem_we = ex_mem_q.mem_wr & ~stall;
  data_mem_sp #(.DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (ex_mem_q.data[ADDR_W-1:0]),
    .wdata(ex_mem_q.wdata),
    .rdata(rd_data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = (mem_op && MEM_WAIT > 0) ? BUSY : IDLE;
    else state_d = (cnt_q == WAIT_C) ? IDLE : BUSY;
  end
  always_comb begin
    stall = mem_op && cnt_q != WAIT_C;
  end
  always_comb begin
    cnt_d = stall ? cnt_q + 1'b1 : '0;
    flush_pending_d = stall & (flush_pending_q | flush);
    ex_mem_in = '{wb_en: writeback_enable, mem_rd: mem_read_enable, mem_wr: mem_write_enable,
                  dest: instruction_dest, data: alu_result, wdata: write_data};
    ex_mem_d = stall ? ex_mem_q : (flush | flush_pending_q) ? EX_MEM_BUBBLE : ex_mem_in;
    // load data is the array value before this cycle's store lands
    mem_wb_d = stall ? MEM_WB_BUBBLE
                     : '{wb_en: ex_mem_q.wb_en, dest: ex_mem_q.dest,
                         data: ex_mem_q.mem_rd ? rd_data : ex_mem_q.data};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_mem_q <= EX_MEM_BUBBLE;
      mem_wb_q <= MEM_WB_BUBBLE;
      cnt_q <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      cnt_q <= cnt_d;
      flush_pending_q <= flush_pending_d;
    end
  assign writeback_enable_out = mem_wb_q.wb_en;
  assign instruction_dest_out = mem_wb_q.dest;
  assign writeback_data_out = mem_wb_q.data;
`ifdef MEMSTAGE_FWD_EN
  assign fwd_valid = ex_mem_q.wb_en & ~ex_mem_q.mem_rd & ~stall;
  assign fwd_dest = ex_mem_q.dest;
  assign fwd_data = ex_mem_q.data;
`endif
endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// tb_mem_wb_pipe_stage: vector table with scoreboard on a zero-wait/16-word instance, hand sequences on a two-wait instance
module tb_mem_wb_pipe_stage;
  typedef struct packed {
    logic wb, rd, wr;
    logic [3:0] dest;
    logic [23:0] alu, wdata;
    logic flush;
  } in_t;
  typedef struct packed {
    logic wb;
    logic [3:0] dest;
    logic [23:0] data;
  } out_t;
  typedef struct {
    in_t i;
    out_t e;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  in_t in0 = '0, in2 = '0;
  logic stall0, wb_o0, stall2, wb_o2;
  logic [3:0] dest_o0, dest_o2;
  logic [23:0] data_o0, data_o2;
  int n_cmp = 0, n_bad = 0;
  out_t sb[$];
  vec_t tbl[12];
`ifdef MEMSTAGE_FWD_EN
  logic fv0, fv2;
  logic [3:0] fd0, fd2;
  logic [23:0] fdat0, fdat2;
`endif
  always #5 clk = ~clk;
  mem_wb_pipe_stage #(.DATA_W(24), .REG_ADDR_W(4), .MEM_DEPTH(16), .MEM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .writeback_enable(in0.wb), .mem_read_enable(in0.rd),
    .mem_write_enable(in0.wr), .instruction_dest(in0.dest), .alu_result(in0.alu),
    .write_data(in0.wdata), .flush(in0.flush), .stall(stall0),
    .writeback_enable_out(wb_o0), .instruction_dest_out(dest_o0), .writeback_data_out(data_o0)
`ifdef MEMSTAGE_FWD_EN
    , .fwd_valid(fv0), .fwd_dest(fd0), .fwd_data(fdat0)
`endif
  );
  mem_wb_pipe_stage #(.DATA_W(24), .REG_ADDR_W(4), .MEM_DEPTH(256), .MEM_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .writeback_enable(in2.wb), .mem_read_enable(in2.rd),
    .mem_write_enable(in2.wr), .instruction_dest(in2.dest), .alu_result(in2.alu),
    .write_data(in2.wdata), .flush(in2.flush), .stall(stall2),
    .writeback_enable_out(wb_o2), .instruction_dest_out(dest_o2), .writeback_data_out(data_o2)
`ifdef MEMSTAGE_FWD_EN
    , .fwd_valid(fv2), .fwd_dest(fd2), .fwd_data(fdat2)
`endif
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic settle2();
    int n = 0;
    while (stall2 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stall_timeout: stall still %0b after %0d cycles", stall2, n);
    end
  endtask
  function automatic out_t o2();
    return {wb_o2, dest_o2, data_o2};
  endfunction
  function automatic in_t mk(input logic wb, rd, wr, input logic [3:0] d,
                             input logic [23:0] a, w, input logic f);
    return {wb, rd, wr, d, a, w, f};
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{mk(1, 0, 0, 1, 24'h1, 0, 0),        '{1'b1, 4'd1, 24'h1}};
    tbl[1]  = '{mk(0, 0, 1, 0, 24'h0, 24'd10, 0),   '{1'b0, 4'd0, 24'h0}};
    tbl[2]  = '{mk(1, 1, 0, 5, 24'h0, 0, 0),        '{1'b1, 4'd5, 24'd10}};
    tbl[3]  = '{mk(0, 0, 1, 0, 24'h11, 24'd7, 0),   '{1'b0, 4'd0, 24'h11}};
    tbl[4]  = '{mk(1, 1, 0, 2, 24'h01, 0, 0),       '{1'b1, 4'd2, 24'd7}};
    tbl[5]  = '{mk(1, 0, 0, 3, 24'h55, 0, 1),       '{1'b0, 4'd0, 24'h0}};
    tbl[6]  = '{mk(1, 1, 1, 4, 24'h01, 24'd9, 0),   '{1'b1, 4'd4, 24'd7}};
    tbl[7]  = '{mk(1, 1, 0, 6, 24'h21, 0, 0),       '{1'b1, 4'd6, 24'd9}};
    tbl[8]  = '{mk(1, 0, 0, 15, 24'hFFFFFF, 0, 0),  '{1'b1, 4'd15, 24'hFFFFFF}};
    tbl[9]  = '{mk(1, 1, 0, 0, 24'h30, 0, 0),       '{1'b1, 4'd0, 24'd10}};
    tbl[10] = '{mk(0, 0, 1, 7, 24'h05, 24'hABCDEF, 0), '{1'b0, 4'd7, 24'h05}};
    tbl[11] = '{mk(1, 1, 0, 9, 24'hF5, 0, 0),       '{1'b1, 4'd9, 24'hABCDEF}};
    #1;
    chk("rst_out0", {stall0, wb_o0, dest_o0, data_o0}, 0);
    chk("rst_out2", {stall2, o2()}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('0);
    sb.push_back('0);
    for (int k = 0; k < 14; k++) begin
      out_t e;
      e = sb.pop_front();
      chk($sformatf("vec%0d_out", k - 2), {wb_o0, dest_o0, data_o0}, e);
      chk($sformatf("vec%0d_stall", k - 2), stall0, 0);
      in0 = k < 12 ? tbl[k].i : '0;
      sb.push_back(k < 12 ? tbl[k].e : out_t'('0));
      step();
    end
    in2 = mk(0, 0, 1, 0, 24'h3, 24'h123, 0);
    step();
    chk("st_stall", stall2, 1);
    in2 = '0;
    settle2();
    step();
    step();
    in2 = mk(1, 1, 0, 5, 24'h3, 0, 0);
    step();
    chk("ld_stall1", {stall2, o2()}, {1'b1, 29'h0});
    in2 = mk(1, 0, 0, 7, 24'h42, 0, 0);
    step();
    chk("ld_stall2", {stall2, o2()}, {1'b1, 29'h0});
    step();
    chk("ld_free", {stall2, o2()}, 0);
    step();
    chk("ld_data", o2(), {1'b1, 4'd5, 24'h123});
    in2 = '0;
    step();
    chk("held_alu", o2(), {1'b1, 4'd7, 24'h42});
    in2 = mk(1, 1, 0, 8, 24'h3, 0, 0);
    step();
    chk("fl_stall", stall2, 1);
    in2 = mk(1, 0, 0, 9, 24'h77, 0, 1);
    step();
    in2.flush = 1'b0;
    step();
    chk("fl_free", stall2, 0);
    step();
    chk("fl_ld_done", o2(), {1'b1, 4'd8, 24'h123});
    in2 = '0;
    step();
    chk("fl_killed", o2(), 0);
    step();
    chk("fl_after", o2(), 0);
    in2 = mk(1, 0, 0, 10, 24'h99, 0, 0);
    step();
    in2 = mk(0, 0, 1, 0, 24'h3, 24'h456, 0);
    step();
    chk("pre_rst", {stall2, o2()}, {1'b1, 1'b1, 4'd10, 24'h99});
    in2 = '0;
    #2 rst = 1'b1;
    #1 chk("rst_mid_busy", {stall2, o2()}, 0);
    @(negedge clk);
    rst = 1'b0;
    in2 = mk(1, 1, 0, 11, 24'h3, 0, 0);
    step();
    in2 = '0;
    settle2();
    step();
    chk("st_aborted", o2(), {1'b1, 4'd11, 24'h123});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
